// File: rtl/fft64_frame_sequencer_if.sv
// Stream, datapath and status bundle between the 64-point frame sequencer and its environment.
// slave is the sequencer's view; master is the upstream/downstream/datapath side.
interface fft64_frame_sequencer_if #(
  parameter int N     = 64,
  parameter int IN_W  = 2,
  parameter int OUT_W = 45,
  parameter int IDX_W = $clog2(N)
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_re;
  logic signed [IN_W-1:0]  in_im;
  logic                    in_last;
  logic [N*IN_W-1:0]       fft_r;
  logic [N*IN_W-1:0]       fft_i;
  logic [N*OUT_W-1:0]      fft_R;
  logic [N*OUT_W-1:0]      fft_I;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_re;
  logic signed [OUT_W-1:0] out_im;
  logic [IDX_W-1:0]        out_idx;
  logic                    out_last;
  logic                    busy;
  logic                    err_frame;

  modport slave (
    input  in_valid, in_re, in_im, in_last, fft_R, fft_I, out_ready,
    output in_ready, fft_r, fft_i, out_valid, out_re, out_im, out_idx, out_last, busy, err_frame
  );

  modport master (
    output in_valid, in_re, in_im, in_last, fft_R, fft_I, out_ready,
    input  in_ready, fft_r, fft_i, out_valid, out_re, out_im, out_idx, out_last, busy, err_frame
  );
endinterface

// File: rtl/fft64_frame_sequencer.sv
// Frame controller for the 64-point FFT datapath: serial load into slot registers,
// fixed-latency wait, then serial unload of the parallel results with backpressure.
module fft64_frame_sequencer #(
  parameter int N       = 64,
  parameter int IN_W    = 2,
  parameter int OUT_W   = 45,
  parameter int FFT_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fft64_frame_sequencer_if.slave    bus
);
  localparam int IDX_W = $clog2(N);
  localparam int LAT_W = (FFT_LAT > 1) ? $clog2(FFT_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_UNLOAD} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_in_idx;
  logic [IDX_W-1:0]   w_in_idx_next;
  logic [IDX_W-1:0]   r_out_idx;
  logic [IDX_W-1:0]   w_out_idx_next;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [LAT_W-1:0]   w_lat_cnt_next;
  logic               r_err;
  logic               w_err_next;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_unload;
  logic signed [OUT_W-1:0] w_bin_re [N];
  logic signed [OUT_W-1:0] w_bin_im [N];

  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_unload   = (r_state == S_UNLOAD);

  always_comb begin
    w_state_next   = r_state;
    w_in_idx_next  = r_in_idx;
    w_out_idx_next = r_out_idx;
    w_lat_cnt_next = r_lat_cnt;
    w_err_next     = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_accept) begin
          if (r_in_idx == IDX_W'(N-1)) begin
            // A missing in_last on the final sample is flagged but the frame still runs.
            w_state_next   = S_WAIT;
            w_lat_cnt_next = LAT_W'(FFT_LAT-1);
            w_in_idx_next  = '0;
            w_err_next     = !bus.in_last;
          end else if (bus.in_last) begin
            w_state_next  = S_IDLE;
            w_in_idx_next = '0;
            w_err_next    = 1'b1;
          end else begin
            w_state_next  = S_LOAD;
            w_in_idx_next = r_in_idx + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_state_next   = S_UNLOAD;
          w_out_idx_next = '0;
        end else begin
          w_lat_cnt_next = r_lat_cnt - 1'b1;
        end
      end
      S_UNLOAD: begin
        if (bus.out_ready) begin
          w_out_idx_next = r_out_idx + 1'b1;
          if (r_out_idx == IDX_W'(N-1)) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_in_idx  <= '0;
      r_out_idx <= '0;
      r_lat_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_in_idx  <= w_in_idx_next;
      r_out_idx <= w_out_idx_next;
      r_lat_cnt <= w_lat_cnt_next;
      r_err     <= w_err_next;
    end
  end

  // Slots only move on an accept, so the datapath sees stable inputs through WAIT and UNLOAD.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      logic signed [IN_W-1:0] r_re;
      logic signed [IN_W-1:0] r_im;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_re <= '0;
          r_im <= '0;
        end else if (w_accept && (r_in_idx == IDX_W'(gi))) begin
          r_re <= bus.in_re;
          r_im <= bus.in_im;
        end
      end

      assign bus.fft_r[gi*IN_W +: IN_W] = r_re;
      assign bus.fft_i[gi*IN_W +: IN_W] = r_im;
      assign w_bin_re[gi] = bus.fft_R[gi*OUT_W +: OUT_W];
      assign w_bin_im[gi] = bus.fft_I[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_unload;
  assign bus.out_re    = w_unload ? w_bin_re[r_out_idx] : '0;
  assign bus.out_im    = w_unload ? w_bin_im[r_out_idx] : '0;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = w_unload && (r_out_idx == IDX_W'(N-1));
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.err_frame = r_err;
endmodule
